// File: rtl/token_embedding_packer_if.sv
// Embedding beat stream: one beat carries LANES 32-bit elements of a token.
// valid/ready handshake; last marks the final beat of a query frame.
interface token_embedding_packer_if #(
  parameter int LANES = 8
) ();
  logic                  valid;
  logic                  ready;
  logic [LANES-1:0][31:0] data;
  logic                  last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/token_embedding_packer.sv
// Packs the encoder beat stream into the token buffer and hands each frame
// to the mean pooler, holding the buffer until the pooler reports done.
module token_embedding_packer #(
  parameter int EMBEDDING_DIM = 384,
  parameter int MAX_TOKENS    = 128,
  parameter int LANES         = 8
) (
  input  logic clk,
  input  logic rst_n,
  token_embedding_packer_if.slave s,
  output logic pool_start,
  input  logic pool_done,
  output logic [$clog2(MAX_TOKENS):0] sequence_length,
  output logic [MAX_TOKENS-1:0][EMBEDDING_DIM-1:0][31:0] token_embeddings,
  output logic frame_done,
  output logic err_partial,
  output logic err_overflow
);
  localparam int BEATS = EMBEDDING_DIM / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(MAX_TOKENS) + 1;
  localparam int TW    = (MAX_TOKENS > 1) ? $clog2(MAX_TOKENS) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_TOKENS);

  typedef enum logic [1:0] {
    PK_FILL,
    PK_START,
    PK_WAIT,
    PK_DONE
  } pk_state_t;

  pk_state_t     state;
  logic [BW-1:0] beat_idx;
  logic [CW-1:0] tok_cnt;
  logic          in_frame;
  logic          wait_first;
  logic          ready_q;

  logic          accept;
  logic          ovf;
  logic          tok_end;
  logic [CW-1:0] tok_inc;
  logic [CW-1:0] fin_cnt;
  logic [TW-1:0] tok_idx;

  assign s.ready = ready_q;

  assign accept  = s.valid && ready_q
                && (state == PK_FILL);
  assign ovf     = (tok_cnt == MAX_CNT);
  assign tok_end = (beat_idx == LAST_BEAT);
  assign tok_inc = ovf ? tok_cnt
                       : tok_cnt + CW'(1);
  // A frame ending mid-token drops that token.
  assign fin_cnt = tok_end ? tok_inc : tok_cnt;
  assign tok_idx = tok_cnt[TW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= PK_FILL;
      beat_idx        <= '0;
      tok_cnt         <= '0;
      in_frame        <= 1'b0;
      wait_first      <= 1'b0;
      ready_q         <= 1'b1;
      pool_start      <= 1'b0;
      frame_done      <= 1'b0;
      err_partial     <= 1'b0;
      err_overflow    <= 1'b0;
      sequence_length <= '0;
    end else begin
      pool_start <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        PK_FILL: begin
          if (accept) begin
            in_frame <= 1'b1;
            if (!in_frame) begin
              err_partial  <= 1'b0;
              err_overflow <= 1'b0;
            end
            if (ovf) begin
              err_overflow <= 1'b1;
            end
            if (s.last) begin
              beat_idx <= '0;
              tok_cnt  <= fin_cnt;
              ready_q  <= 1'b0;
              if (!tok_end) begin
                err_partial <= 1'b1;
              end
              if (fin_cnt != '0) begin
                sequence_length <= fin_cnt;
                pool_start      <= 1'b1;
                state           <= PK_START;
              end else begin
                frame_done <= 1'b1;
                state      <= PK_DONE;
              end
            end else if (tok_end) begin
              beat_idx <= '0;
              tok_cnt  <= tok_inc;
            end else begin
              beat_idx <= beat_idx + BW'(1);
            end
          end
        end
        PK_START: begin
          wait_first <= 1'b1;
          state      <= PK_WAIT;
        end
        PK_WAIT: begin
          // Pooler clears its stale done during our first wait cycle.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (pool_done) begin
            frame_done <= 1'b1;
            state      <= PK_DONE;
          end
        end
        PK_DONE: begin
          beat_idx <= '0;
          tok_cnt  <= '0;
          in_frame <= 1'b0;
          ready_q  <= 1'b1;
          state    <= PK_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token_embeddings <= '0;
    end else if (accept && !ovf) begin
      for (int t = 0; t < MAX_TOKENS; t++) begin
        for (int b = 0; b < BEATS; b++) begin
          if (tok_idx == TW'(t)
              && beat_idx == BW'(b)) begin
            for (int l = 0; l < LANES; l++) begin
              token_embeddings[t][b*LANES+l]
                <= s.data[l];
            end
          end
        end
      end
    end
  end
endmodule
